// File: rtl/aes_bram_pkg.sv
// Shared constants, FSM state type and address helpers
// for the stages that feed the masked S-box BRAM.
package aes_bram_pkg;

   // Read latency of the BRAM with its output register enabled.
   localparam int BRAM_LAT = 2;
   localparam int NBYTES   = 16;
   localparam int NPAIRS   = NBYTES / 2;
   localparam int KW       = $clog2(NPAIRS);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // A table address is the select in the top two bits
   // and the state byte below it.
   function automatic logic [9:0] bram_addr(
      input logic [1:0] sel,
      input logic [7:0] b
   );
      return {sel, b};
   endfunction

   function automatic logic [7:0] state_byte(
      input logic [8*NBYTES-1:0] s,
      input logic [KW:0]         i
   );
      return s[8*i +: 8];
   endfunction

endpackage

// File: rtl/lat_pipe.sv
// DEPTH-deep shift register that carries a tag alongside BRAM reads.
// Ports: clk, rst (sync, active-high), d (tag in), q (tag DEPTH cycles later).
module lat_pipe
   import aes_bram_pkg::*;
#(
   parameter int DEPTH = BRAM_LAT,
   parameter int W     = 1 + KW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr[i] <= '0;
         end
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// Issues a 128-bit masked share to the S-box BRAM two bytes per cycle and
// reassembles the registered read data into one SubBytes result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_state/in_sel
// (share input); ADDRA/ADDRB/EN (to BRAM); DOA/DOB (from BRAM);
// out_valid/out_ready/out_state (result output).
module masked_subbytes_seq
   import aes_bram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_state,
   input  logic [1:0]            in_sel,
   output logic [9:0]            ADDRA,
   output logic [9:0]            ADDRB,
   output logic                  EN,
   input  logic [7:0]            DOA,
   input  logic [7:0]            DOB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_state
);

   state_t              state, state_d;
   logic [KW-1:0]       k, k_d, k_nx;
   logic [8*NBYTES-1:0] st_q, st_d;
   logic [1:0]          sel_q, sel_d;
   logic [9:0]          addra_d, addrb_d;
   logic                en_d, ov_d;

   logic [KW:0]         pin, pout;

   assign in_ready = (state == IDLE) && !rst;
   assign k_nx     = k + 1'b1;

   always_comb begin
      state_d = state;
      k_d     = k;
      st_d    = st_q;
      sel_d   = sel_q;
      addra_d = ADDRA;
      addrb_d = ADDRB;
      en_d    = EN;
      ov_d    = out_valid;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               state_d = ISSUE;
               k_d     = '0;
               st_d    = in_state;
               sel_d   = in_sel;
               // Pair 0 goes out on the accept edge so the
               // address registers lead the ISSUE counter.
               addra_d = bram_addr(in_sel, in_state[7:0]);
               addrb_d = bram_addr(in_sel, in_state[15:8]);
               en_d    = 1'b1;
            end
         end
         ISSUE: begin
            if (k == KW'(NPAIRS - 1)) begin
               state_d = DRAIN;
               k_d     = '0;
            end else begin
               k_d     = k_nx;
               addra_d = bram_addr(sel_q,
                  state_byte(st_q, {k_nx, 1'b0}));
               addrb_d = bram_addr(sel_q,
                  state_byte(st_q, {k_nx, 1'b1}));
            end
         end
         DRAIN: begin
            // k is reused as the drain counter.
            if (k == KW'(BRAM_LAT - 1)) begin
               state_d = DONE;
               en_d    = 1'b0;
               ov_d    = 1'b1;
            end else begin
               k_d = k_nx;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               ov_d    = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         st_q      <= '0;
         sel_q     <= '0;
         ADDRA     <= '0;
         ADDRB     <= '0;
         EN        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_d;
         k         <= k_d;
         st_q      <= st_d;
         sel_q     <= sel_d;
         ADDRA     <= addra_d;
         ADDRB     <= addrb_d;
         EN        <= en_d;
         out_valid <= ov_d;
      end
   end

   // The tag enters while pair k is on the address bus and
   // comes out in the cycle its data sits on DOA/DOB.
   assign pin = {state == ISSUE, k};

   lat_pipe #(
      .DEPTH (BRAM_LAT),
      .W     (KW + 1)
   ) u_lat (
      .clk (clk),
      .rst (rst),
      .d   (pin),
      .q   (pout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_state <= '0;
      end else if (pout[KW]) begin
         out_state[16*pout[KW-1:0] +: 16] <= {DOB, DOA};
      end
   end

endmodule
